// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack
// and hands words to the CU over valid/ready. Optional timeout: FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  PC,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
`ifdef FETCH_TIMEOUT_EN
        , S_FAULT
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  w_fetch_pc_next;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_flush;
    logic               w_flush_next;
    logic               w_capture;
    logic               w_timeout;

`ifdef FETCH_TIMEOUT_EN
    localparam int                  TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    logic [TIMER_W-1:0] r_timer;
    logic               r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
            r_fault <= 1'b0;
        end else begin
            if (r_state == S_REQ && !mem_ack)
                r_timer <= r_timer + 1'b1;
            else
                r_timer <= '0;
            if (w_timeout)
                r_fault <= 1'b1;
        end
    end

    assign w_timeout   = (r_state == S_REQ) && !mem_ack && (r_timer == TIMER_LAST);
    assign fetch_fault = r_fault;
`else
    assign w_timeout   = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = redirect ? redirect_pc : r_fetch_pc;
        w_flush_next    = r_flush;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en)
                    w_state_next = S_REQ;
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_flush_next = 1'b0;
                    if (r_flush || redirect) begin
                        w_state_next = en ? S_REQ : S_IDLE;
                    end else begin
                        w_capture       = 1'b1;
                        w_fetch_pc_next = r_fetch_pc + 1'b1;
                        w_state_next    = S_HOLD;
                    end
                end else begin
                    // The in-flight read must still complete; its word is dropped.
                    if (redirect)
                        w_flush_next = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    if (w_timeout) begin
                        w_state_next = S_FAULT;
                        w_flush_next = 1'b0;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (instr_ready || redirect)
                    w_state_next = en ? S_REQ : S_IDLE;
            end
`ifdef FETCH_TIMEOUT_EN
            S_FAULT: begin
                w_fetch_pc_next = r_fetch_pc;
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_flush    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_flush    <= w_flush_next;
            // Address is frozen while a read is outstanding.
            if (r_state != S_REQ || mem_ack)
                r_mem_addr <= w_fetch_pc_next;
            if (w_capture) begin
                r_instr <= mem_rdata;
                r_pc    <= r_fetch_pc;
            end
        end
    end

    assign mem_req     = (r_state == S_REQ);
    assign mem_addr    = r_mem_addr;
    assign instr_valid = (r_state == S_HOLD);
    assign instruction = r_instr;
    assign PC          = r_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: transaction-level model plus directed
// vectors; a second instance with RESET_PC=0xFE checks wrap and throughput.
module tb_instr_fetch;

    localparam int TIMEOUT = 15;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en, mem_ack, redirect, instr_ready;
    logic [15:0] mem_rdata;
    logic [7:0]  redirect_pc;
    logic        mem_req, instr_valid, fetch_fault;
    logic [7:0]  mem_addr, PC;
    logic [15:0] instruction;

    logic        en_w;
    logic        mem_req_w, instr_valid_w, fetch_fault_w;
    logic [7:0]  mem_addr_w, PC_w;
    logic [15:0] instruction_w, mem_rdata_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instruction(instruction), .PC(PC), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_fault(fetch_fault)
    );

    // Zero-wait memory returning {0x5A, addr}, CU always ready.
    assign mem_rdata_w = {8'h5A, mem_addr_w};

    instr_fetch #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE), .TIMEOUT(TIMEOUT)) u_dut_wrap (
        .clk(clk), .rst(rst), .en(en_w),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_req_w), .mem_rdata(mem_rdata_w),
        .redirect(1'b0), .redirect_pc(8'h00),
        .instruction(instruction_w), .PC(PC_w), .instr_valid(instr_valid_w),
        .instr_ready(1'b1), .fetch_fault(fetch_fault_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a read is in flight, a word is held, or neither.
    bit          m_busy, m_have, m_discard, m_fault, m_start;
    logic [7:0]  m_next, m_addr, m_pc, m_nxt;
    logic [15:0] m_word;
    int          m_wait;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_have = 0; m_discard = 0; m_fault = 0;
            m_next = 8'h00; m_addr = 8'h00; m_pc = 8'h00; m_word = 16'h0; m_wait = 0;
        end else if (!m_fault) begin
            m_start = 0;
            m_nxt   = redirect ? redirect_pc : m_next;
            if (m_busy) begin
                if (mem_ack) begin
                    m_busy = 0;
                    m_wait = 0;
                    if (m_discard || redirect) begin
                        m_start = en;
                    end else begin
                        m_have = 1;
                        m_word = mem_rdata;
                        m_pc   = m_addr;
                        m_nxt  = m_addr + 8'd1;
                    end
                    m_discard = 0;
                end else begin
                    if (redirect) m_discard = 1;
                    m_wait++;
                    if (TIMEOUT_EN && m_wait == TIMEOUT) begin
                        m_fault = 1;
                        m_busy  = 0;
                    end
                end
            end else if (m_have) begin
                if (instr_ready || redirect) begin
                    m_have  = 0;
                    m_start = en;
                end
            end else begin
                m_start = en;
            end
            if (!m_fault) m_next = m_nxt;
            if (m_start) begin
                m_busy = 1;
                m_addr = m_nxt;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mdl_mem_req", 32'(mem_req), 32'(m_busy));
            if (m_busy) check("mdl_mem_addr", 32'(mem_addr), 32'(m_addr));
            check("mdl_instr_valid", 32'(instr_valid), 32'(m_have));
            check("mdl_instruction", 32'(instruction), 32'(m_word));
            check("mdl_PC", 32'(PC), 32'(m_pc));
            check("mdl_fetch_fault", 32'(fetch_fault), 32'(m_fault));
        end
    end

    logic [7:0]  pcs_w [4];
    logic [15:0] ins_w [4];
    int          cyc_w [4];
    int          n_w = 0;

    always @(negedge clk) begin
        if (!rst && instr_valid_w && n_w < 4) begin
            pcs_w[n_w] = PC_w;
            ins_w[n_w] = instruction_w;
            cyc_w[n_w] = cycle;
            n_w++;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; en_w = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;
        redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
        step(); step();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 'h00);
        check("rst_PC", 32'(PC), 'h00);
        check("rst_instruction", 32'(instruction), 'h0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_fetch_fault", 32'(fetch_fault), 0);
        check("rst_wrap_mem_addr", 32'(mem_addr_w), 'hFE);
        check("rst_wrap_PC", 32'(PC_w), 'hFE);

        // First fetch: one cycle en->req, one cycle ack->valid.
        rst = 1'b0; en = 1'b1; en_w = 1'b1;
        step();
        check("first_mem_req", 32'(mem_req), 1);
        check("first_mem_addr", 32'(mem_addr), 'h00);
        mem_ack = 1'b1; mem_rdata = 16'hA123;
        step();
        mem_ack = 1'b0;
        check("first_valid", 32'(instr_valid), 1);
        check("first_instruction", 32'(instruction), 'hA123);
        check("first_PC", 32'(PC), 'h00);

        // Stall the CU for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(instr_valid), 1);
            check("stall_instruction", 32'(instruction), 'hA123);
            check("stall_PC", 32'(PC), 'h00);
            check("stall_mem_req", 32'(mem_req), 0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("next_mem_req", 32'(mem_req), 1);
        check("next_mem_addr", 32'(mem_addr), 'h01);

        // Wrap instance: PCs FE, FF, 00, one every 2 cycles.
        check("wrap_count", n_w >= 3, 1);
        check("wrap_pc0", 32'(pcs_w[0]), 'hFE);
        check("wrap_pc1", 32'(pcs_w[1]), 'hFF);
        check("wrap_pc2", 32'(pcs_w[2]), 'h00);
        check("wrap_instr0", 32'(ins_w[0]), 'h5AFE);
        check("wrap_instr2", 32'(ins_w[2]), 'h5A00);
        check("wrap_rate01", cyc_w[1] - cyc_w[0], 2);
        check("wrap_rate12", cyc_w[2] - cyc_w[1], 2);
        check("wrap_fault", 32'(fetch_fault_w), 0);

        // Redirect to 0x40 while the read of 0x01 is outstanding.
        redirect = 1'b1; redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_mem_addr", 32'(mem_addr), 'h01);
            check("flush_mem_req", 32'(mem_req), 1);
            if (i < 2) step();
        end
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_ack = 1'b0;
        check("flush_discard_valid", 32'(instr_valid), 0);
        check("flush_new_addr", 32'(mem_addr), 'h40);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0;
        check("flush_first_PC", 32'(PC), 'h40);
        check("flush_first_instr", 32'(instruction), 'h1111);

        // Redirect to 0x10 together with ready in HOLD.
        redirect = 1'b1; redirect_pc = 8'h10; instr_ready = 1'b1;
        step();
        redirect = 1'b0; instr_ready = 1'b0;
        check("hold_redir_addr", 32'(mem_addr), 'h10);
        check("hold_redir_valid", 32'(instr_valid), 0);

        // Redirect coinciding with ack: word dropped, refetch at 0x20.
        mem_ack = 1'b1; mem_rdata = 16'hBAD0; redirect = 1'b1; redirect_pc = 8'h20;
        step();
        mem_ack = 1'b0; redirect = 1'b0;
        check("ack_redir_addr", 32'(mem_addr), 'h20);
        check("ack_redir_valid", 32'(instr_valid), 0);

        // en dropped mid-read: the read completes, then IDLE.
        en = 1'b0;
        step(); step();
        check("en_drop_req", 32'(mem_req), 1);
        mem_ack = 1'b1; mem_rdata = 16'h2222;
        step();
        mem_ack = 1'b0;
        check("en_drop_PC", 32'(PC), 'h20);
        check("en_drop_instr", 32'(instruction), 'h2222);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("idle_req", 32'(mem_req), 0);

        // Stray ack while idle.
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        step();
        mem_ack = 1'b0;
        check("stray_ack_valid", 32'(instr_valid), 0);
        check("stray_ack_instr", 32'(instruction), 'h2222);

        // Two redirects during one flush: the last one wins.
        en = 1'b1;
        step();
        check("dbl_first_addr", 32'(mem_addr), 'h21);
        redirect = 1'b1; redirect_pc = 8'h50;
        step();
        redirect_pc = 8'h60;
        step();
        redirect = 1'b0;
        check("dbl_held_addr", 32'(mem_addr), 'h21);
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        step();
        check("dbl_new_addr", 32'(mem_addr), 'h60);
        mem_rdata = 16'h6060;
        step();
        mem_ack = 1'b0;
        check("dbl_PC", 32'(PC), 'h60);
        check("dbl_instr", 32'(instruction), 'h6060);

        // Redirect in HOLD without ready, en low: drop to IDLE, then fetch target.
        en = 1'b0; redirect = 1'b1; redirect_pc = 8'h80;
        step();
        redirect = 1'b0;
        check("hold_redir_drop_valid", 32'(instr_valid), 0);
        check("hold_redir_idle", 32'(mem_req), 0);
        en = 1'b1;
        step();
        check("hold_redir_addr2", 32'(mem_addr), 'h80);

        // Memory never answers.
        for (int i = 0; i < 20; i++) step();
`ifdef FETCH_TIMEOUT_EN
        check("timeout_fault", 32'(fetch_fault), 1);
        check("timeout_req", 32'(mem_req), 0);
`else
        check("no_timeout_req", 32'(mem_req), 1);
        check("no_timeout_addr", 32'(mem_addr), 'h80);
`endif

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check("async_rst_req", 32'(mem_req), 0);
        check("async_rst_addr", 32'(mem_addr), 'h00);
        check("async_rst_PC", 32'(PC), 'h00);
        check("async_rst_fault", 32'(fetch_fault), 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_addr", 32'(mem_addr), 'h00);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        check("post_rst_instr", 32'(instruction), 'h1234);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
